// File: rtl/dcache_flush_unit_pkg.sv
// Shared types and default sizing for the data-cache flush unit.
// Holds the flush/init FSM state encoding and the default cache geometry.
package ariane_pkg;

    localparam int unsigned DCACHE_NR_SETS     = 256;
    localparam int unsigned DCACHE_NR_WAYS     = 4;
    localparam int unsigned DCACHE_ADDR_W      = 56;
    localparam int unsigned DCACHE_LINE_OFFSET = 4;

    // state      | meaning
    // INIT_WAIT  | waiting for cache_init_ni low before invalidating everything
    // INIT       | invalidating one entry per cycle over the whole array
    // IDLE       | nothing in progress, accepts flush or init requests
    // READ       | tag-array read strobe for the current entry
    // CHECK      | read data present, decide writeback / invalidate / skip
    // WB_REQ     | writeback requested, address held until granted
    // WB_WAIT    | writeback granted, waiting for completion
    // INV        | invalidate the current entry
    // ACK_WAIT   | ack sent, waiting for the request level to drop
    typedef enum logic [3:0] {
        INIT_WAIT,
        INIT,
        IDLE,
        READ,
        CHECK,
        WB_REQ,
        WB_WAIT,
        INV,
        ACK_WAIT
    } dcache_flush_state_e;

endpackage

// File: rtl/dcache_flush_unit_if.sv
// Tag-array access and writeback bus between the flush unit (master)
// and the cache array / memory side (slave).
interface dcache_flush_unit_if
    import ariane_pkg::*;
#(
    parameter int unsigned IDX_W  = $clog2(DCACHE_NR_SETS),
    parameter int unsigned WAY_W  = 2,
    parameter int unsigned TAG_W  = DCACHE_ADDR_W - IDX_W - DCACHE_LINE_OFFSET,
    parameter int unsigned ADDR_W = DCACHE_ADDR_W
);
    logic              arr_rd_o;
    logic [IDX_W-1:0]  arr_idx_o;
    logic [WAY_W-1:0]  arr_way_o;
    logic              arr_inv_o;
    logic              arr_valid_i;
    logic              arr_dirty_i;
    logic [TAG_W-1:0]  arr_tag_i;
    logic              wb_req_o;
    logic              wb_gnt_i;
    logic [ADDR_W-1:0] wb_addr_o;
    logic              wb_done_i;

    modport master (
        output arr_rd_o, arr_idx_o, arr_way_o, arr_inv_o, wb_req_o, wb_addr_o,
        input  arr_valid_i, arr_dirty_i, arr_tag_i, wb_gnt_i, wb_done_i
    );

    modport slave (
        input  arr_rd_o, arr_idx_o, arr_way_o, arr_inv_o, wb_req_o, wb_addr_o,
        output arr_valid_i, arr_dirty_i, arr_tag_i, wb_gnt_i, wb_done_i
    );
endinterface

// File: rtl/dcache_flush_unit_cnt.sv
// Walk counter for the flush unit: clearable, wrapping up-counter with a
// last-value flag. The way sits in the LSBs so the walk is way-minor.
module dcache_flush_unit_cnt #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             last_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    // next count: clear wins over increment, increment wraps to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_o = &cnt_q;
endmodule

// File: rtl/dcache_flush_unit.sv
// Data-cache flush unit: invalidate-all after init, and on a flush request
// walks every set/way, writing back dirty lines and invalidating valid ones.
// Optional feature macro: DCACHE_FLUSH_STATS_EN adds flush_cycles_o.
module dcache_flush_unit
    import ariane_pkg::*;
#(
    parameter int unsigned NR_SETS     = DCACHE_NR_SETS,
    parameter int unsigned NR_WAYS     = DCACHE_NR_WAYS,
    parameter int unsigned ADDR_W      = DCACHE_ADDR_W,
    parameter int unsigned LINE_OFFSET = DCACHE_LINE_OFFSET
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    output logic        flush_ack_o,
    input  logic        cache_init_ni,
    output logic        busy_o,
`ifdef DCACHE_FLUSH_STATS_EN
    output logic [31:0] flush_cycles_o,
`endif
    dcache_flush_unit_if.master bus
);
    localparam int unsigned IDX_W    = $clog2(NR_SETS);
    localparam int unsigned WAY_W    = (NR_WAYS > 1) ? $clog2(NR_WAYS) : 1;
    localparam int unsigned TAG_W    = ADDR_W - IDX_W - LINE_OFFSET;
    // a single-way cache has no way bits in the walk, only the set index
    localparam int unsigned WAYS_LOG = $clog2(NR_WAYS);
    localparam int unsigned WALK_W   = IDX_W + WAYS_LOG;

    dcache_flush_state_e state_q, state_d;
    logic                ack_q, ack_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                init_prev_q;
    logic                cnt_clr, cnt_en, advance, walk_last;
    logic                rd, inv, wb_req;
    logic [WALK_W-1:0]   walk;
    logic [IDX_W-1:0]    idx;

    dcache_flush_unit_cnt #(.WIDTH(WALK_W)) i_walk_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (cnt_clr),
        .en_i   (cnt_en),
        .cnt_o  (walk),
        .last_o (walk_last)
    );

    assign idx = walk[WALK_W-1 -: IDX_W];

    if (WAYS_LOG > 0) begin : g_way
        assign bus.arr_way_o = walk[WAYS_LOG-1:0];
    end else begin : g_one_way
        assign bus.arr_way_o = '0;
    end

    // next-state and strobe decode
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        tag_d   = tag_q;
        cnt_clr = 1'b0;
        advance = 1'b0;
        rd      = 1'b0;
        inv     = 1'b0;
        wb_req  = 1'b0;
        unique case (state_q)
            INIT_WAIT: if (!cache_init_ni) begin
                state_d = INIT;
                cnt_clr = 1'b1;
            end
            INIT: begin
                inv = 1'b1;
                if (walk_last) state_d = IDLE;
            end
            IDLE: begin
                if (cache_init_ni && !init_prev_q) begin
                    state_d = INIT_WAIT;
                end else if (flush_i) begin
                    state_d = READ;
                    cnt_clr = 1'b1;
                end
            end
            READ: begin
                rd      = 1'b1;
                state_d = CHECK;
            end
            CHECK: begin
                tag_d = bus.arr_tag_i;
                if (bus.arr_valid_i && bus.arr_dirty_i) state_d = WB_REQ;
                else if (bus.arr_valid_i)               state_d = INV;
                else                                    advance = 1'b1;
            end
            WB_REQ: begin
                wb_req = 1'b1;
                if (bus.wb_gnt_i) state_d = WB_WAIT;
            end
            WB_WAIT: if (bus.wb_done_i) state_d = INV;
            INV: begin
                inv     = 1'b1;
                advance = 1'b1;
            end
            ACK_WAIT: if (!flush_i) state_d = IDLE;
            default: state_d = INIT_WAIT;
        endcase
        if (advance) begin
            if (walk_last) begin
                ack_d   = 1'b1;
                state_d = ACK_WAIT;
            end else begin
                state_d = READ;
            end
        end
    end

    // the walk counter wraps to zero after the last entry, so it steps on every
    // init cycle and on every flush advance
    assign cnt_en = (state_q == INIT) || advance;

    // state, ack pulse, captured tag and init-level history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT_WAIT;
            ack_q       <= 1'b0;
            tag_q       <= '0;
            init_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            tag_q       <= tag_d;
            init_prev_q <= cache_init_ni;
        end
    end

    assign busy_o        = (state_q != IDLE);
    assign flush_ack_o   = ack_q;
    assign bus.arr_rd_o  = rd;
    assign bus.arr_inv_o = inv;
    assign bus.arr_idx_o = idx;
    assign bus.wb_req_o  = wb_req;
    assign bus.wb_addr_o = {tag_q, idx, {LINE_OFFSET{1'b0}}};

`ifdef DCACHE_FLUSH_STATS_EN
    logic [31:0] run_cnt_q, run_cnt_d, flush_cycles_q, flush_cycles_d;

    // run_cnt_q equals the number of cycles since leaving IDLE, saturating
    always_comb begin
        run_cnt_d      = run_cnt_q;
        flush_cycles_d = flush_cycles_q;
        if (state_q == IDLE && state_d == READ) begin
            run_cnt_d = 32'd1;
        end else if ((state_q inside {READ, CHECK, WB_REQ, WB_WAIT, INV}) && (run_cnt_q != '1)) begin
            run_cnt_d = run_cnt_q + 32'd1;
        end
        if (ack_d) begin
            flush_cycles_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + 32'd1;
        end
    end

    // statistics registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_cnt_q      <= '0;
            flush_cycles_q <= '0;
        end else begin
            run_cnt_q      <= run_cnt_d;
            flush_cycles_q <= flush_cycles_d;
        end
    end

    assign flush_cycles_o = flush_cycles_q;
`endif
endmodule

// File: doc/dcache_flush_unit.md
DCACHE_FLUSH_UNIT -- requirements
Module: dcache_flush_unit

Interface
REQ-001 SHALL have parameter NR_SETS, default 256: cache sets, power of two, at least 2.
REQ-002 SHALL have parameter NR_WAYS, default 4: ways per set, power of two, at least 1.
REQ-003 SHALL have parameter ADDR_W, default 56: physical address width.
REQ-004 SHALL have parameter LINE_OFFSET, default 4: byte-offset bits per line.
REQ-005 SHALL have parameter derivations IDX_W=$clog2(NR_SETS), WAY_W=max(1,$clog2(NR_WAYS)) and TAG_W=ADDR_W-IDX_W-LINE_OFFSET.
REQ-006 SHALL have port clk_i, input, 1 bit: single clock.
REQ-007 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port flush_i, input, 1 bit: flush request, a level held by the controller until after the ack.
REQ-009 SHALL have port flush_ack_o, output, 1 bit: flush done, a one-cycle pulse.
REQ-010 SHALL have port cache_init_ni, input, 1 bit: low means the invalidate-all init is allowed.
REQ-011 SHALL have port busy_o, output, 1 bit: unit not IDLE.
REQ-012 SHALL have port arr_rd_o, input-side direction output, 1 bit: tag-array read strobe.
REQ-013 SHALL have port arr_idx_o, output, IDX_W bits: array set index.
REQ-014 SHALL have port arr_way_o, output, WAY_W bits: array way.
REQ-015 SHALL have port arr_valid_i, input, 1 bit: read data, one cycle after arr_rd_o.
REQ-016 SHALL have port arr_dirty_i, input, 1 bit: read data, one cycle after arr_rd_o.
REQ-017 SHALL have port arr_tag_i, input, TAG_W bits: read data, one cycle after arr_rd_o.
REQ-018 SHALL have port arr_inv_o, output, 1 bit: clear valid and dirty at arr_idx_o/arr_way_o.
REQ-019 SHALL have port wb_req_o, output, 1 bit: writeback request.
REQ-020 SHALL have port wb_gnt_i, input, 1 bit: writeback grant.
REQ-021 SHALL have port wb_addr_o, output, ADDR_W bits: writeback address {tag, idx, LINE_OFFSET zeros}.
REQ-022 SHALL have port wb_done_i, input, 1 bit: writeback completion.

Function
REQ-023 SHALL have states INIT_WAIT, INIT, IDLE, READ, CHECK, WB_REQ, WB_WAIT, INV and ACK_WAIT.
REQ-024 SHALL leave INIT_WAIT for INIT in the cycle after cache_init_ni is seen low.
REQ-025 SHALL, in INIT, assert arr_inv_o once per cycle over all NR_SETS×NR_WAYS entries, way-minor order, then go to IDLE, with no array reads and no writebacks.
REQ-026 SHALL, when cache_init_ni rises in IDLE, go to INIT_WAIT; cache_init_ni SHALL be ignored in every other state.
REQ-027 SHALL, on flush_i seen high in IDLE, clear the idx/way counters and go to READ.
REQ-028 SHALL, in READ, assert arr_rd_o for one cycle and then go to CHECK.
REQ-029 SHALL, in CHECK, go to WB_REQ if valid and dirty, else to INV if valid, else advance.
REQ-030 SHALL, in WB_REQ, hold wb_req_o and a stable wb_addr_o until wb_gnt_i, then go to WB_WAIT.
REQ-031 SHALL, in WB_WAIT, wait for wb_done_i and then go to INV.
REQ-032 SHALL have one writeback outstanding at most.
REQ-033 SHALL, in INV, assert arr_inv_o for one cycle and then advance.
REQ-034 SHALL, on advance, increment the way, wrap it, and increment the idx on the way wrap.
REQ-035 SHALL, after the last idx/way, pulse flush_ack_o for one cycle and go to ACK_WAIT.
REQ-036 SHALL stay in ACK_WAIT until flush_i is low, then go to IDLE, so that a still-high request is never re-served.
REQ-037 SHALL assert busy_o in every state except IDLE.
REQ-038 SHALL have a best-case latency from flush request to ack of 2 cycles per clean invalid entry, plus 1 cycle for the pulse.
REQ-039 SHALL make a wb_done_i without an outstanding request, or an arr_* response outside CHECK, a don't-care that is ignored.

Reset
REQ-040 SHALL, with rst_i high on a clock edge, go to INIT_WAIT, zero the counters and abandon any writeback in flight.
REQ-041 SHALL reset all outputs to 0: flush_ack_o, busy_o=1 (INIT_WAIT), arr_rd_o, arr_inv_o, wb_req_o, arr_idx_o, arr_way_o and wb_addr_o.

Configuration
REQ-042 SHALL, with DCACHE_FLUSH_STATS_EN defined, add output flush_cycles_o (32 bits), a saturating count of cycles from the IDLE exit to flush_ack_o of the last flush, updated on the ack and reset to 0.
REQ-043 SHALL, without DCACHE_FLUSH_STATS_EN, have neither the port nor the logic.

Structure
REQ-044 SHALL place the state enum dcache_flush_state_e and the default parameter constants in ariane_pkg.
REQ-045 SHALL use one sub-module, the existing counter, for the combined idx/way walk counter (width IDX_W+WAY_W), with the way in the LSBs.

Verification (NR_SETS=4, NR_WAYS=2, LINE_OFFSET=4, ADDR_W=32)
REQ-046 SHALL pass: reset, cache_init_ni=1 for 5 cycles then 0 -> 8 arr_inv_o pulses over idx0w0..idx3w1, then IDLE and busy_o=0.
REQ-047 SHALL pass: flush with all lines invalid -> 8 reads, no wb_req_o, one flush_ack_o pulse 17 cycles after the request.
REQ-048 SHALL pass: idx2w1 valid, dirty, tag 0x1234, wb_gnt_i after 3 cycles -> wb_addr_o stable at 0x0048D20 until grant, arr_inv_o only after wb_done_i.
REQ-049 SHALL pass: flush_i held 3 cycles after the ack -> exactly one ack, then IDLE only after flush_i falls.
REQ-050 SHALL pass: rst_i asserted in WB_WAIT -> wb_req_o=0 next cycle, state INIT_WAIT, no ack.
REQ-051 SHALL pass, with DCACHE_FLUSH_STATS_EN: the REQ-047 flush -> flush_cycles_o=17.
